exe_stage_pipelined: RTL

- Parametrised execute stage for the ARM-subset pipeline.
- Performs operand forwarding, Val2 generation (immediate rotate, register shift, memory offset), ALU operations, an iterative multi-cycle multiply, branch-target computation and status-register update.
- Contains the registered EXE/MEM pipeline register and an internal NZCV status register.
- Sits between the ID/EXE register and the memory stage; it stalls upstream while a multiply is in progress.

---
 rtl/exe_pkg.sv | 49 ++++
 rtl/val2_gen_param.sv | 55 +++++
 rtl/exe_stage_pipelined.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : exe_pkg
// Brief    : Shared constants for the execute stage: ALU opcodes, shifter
//            types, forwarding selects and NZCV bit positions.
// Revision : 1.0 - initial release
// ============================================================================
package exe_pkg;

    // ALU opcodes carried on exe_cmd
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_MUL = 4'b1010;

    // Register-shift types from shift_operand[6:5]
    localparam logic [1:0] c_SHIFT_LSL = 2'b00;
    localparam logic [1:0] c_SHIFT_LSR = 2'b01;
    localparam logic [1:0] c_SHIFT_ASR = 2'b10;
    localparam logic [1:0] c_SHIFT_ROR = 2'b11;

    // Forwarding selects; 11 is an alias for the ID value
    localparam logic [1:0] c_FWD_ID     = 2'b00;
    localparam logic [1:0] c_FWD_MEM    = 2'b01;
    localparam logic [1:0] c_FWD_WB     = 2'b10;
    localparam logic [1:0] c_FWD_ID_ALT = 2'b11;

    // Bit positions inside the NZCV status vector
    localparam int c_FLAG_N = 3;
    localparam int c_FLAG_Z = 2;
    localparam int c_FLAG_C = 1;
    localparam int c_FLAG_V = 0;

    typedef logic [3:0] nzcv_t;

    // Opcodes resolved in a single cycle by the ALU (multiply excluded)
    function automatic logic exe_cmd_is_alu(input logic [3:0] cmd);
        return cmd inside {EXE_MOV, EXE_MVN, EXE_ADD, EXE_ADC, EXE_SUB,
                           EXE_SBC, EXE_AND, EXE_ORR, EXE_EOR};
    endfunction

endpackage
`default_nettype wire

// File: rtl/val2_gen_param.sv
`default_nettype none
// ============================================================================
// Module   : val2_gen_param
// Brief    : Second-operand generator: memory offset, rotated immediate, or
//            register shifted by an immediate amount (LSL/LSR/ASR/ROR).
// Revision : 1.0 - initial release
// ============================================================================
module val2_gen_param
    import exe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_rm,
    input  logic [11:0]       i_shift_operand,
    input  logic              i_imm,
    input  logic              i_mem_en,
    output logic [DATA_W-1:0] o_val2
);

    logic [4:0]        w_shamt;
    logic [1:0]        w_sh_type;
    logic [4:0]        w_rot;
    logic [DATA_W-1:0] w_imm8;
    logic [DATA_W-1:0] w_imm_rot;
    logic [DATA_W-1:0] w_rm_ror;

    assign w_shamt   = i_shift_operand[11:7];
    assign w_sh_type = i_shift_operand[6:5];
    // Rotate amount is twice the 4-bit field
    assign w_rot     = {i_shift_operand[11:8], 1'b0};
    assign w_imm8    = {{(DATA_W-8){1'b0}}, i_shift_operand[7:0]};

    // A zero amount makes the left term shift out completely, leaving x
    assign w_imm_rot = (w_imm8 >> w_rot) | (w_imm8 << (DATA_W - int'(w_rot)));
    assign w_rm_ror  = (i_rm >> w_shamt) | (i_rm << (DATA_W - int'(w_shamt)));

    // Select the operand form: memory offset wins over immediate over shift
    always_comb begin
        o_val2 = i_rm;
        if (i_mem_en) begin
            o_val2 = {{(DATA_W-12){1'b0}}, i_shift_operand};
        end else if (i_imm) begin
            o_val2 = w_imm_rot;
        end else begin
            case (w_sh_type)
                c_SHIFT_LSL: o_val2 = i_rm << w_shamt;
                c_SHIFT_LSR: o_val2 = i_rm >> w_shamt;
                c_SHIFT_ASR: o_val2 = $signed(i_rm) >>> w_shamt;
                default:     o_val2 = w_rm_ror;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/exe_stage_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : exe_stage_pipelined
// Brief    : Execute stage with forwarding, Val2 generation, ALU, iterative
//            multiplier, branch target, NZCV register and EXE/MEM register.
// Revision : 1.0 - initial release
// ============================================================================
module exe_stage_pipelined
    import exe_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int REG_ADDR_W     = 4,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic                  flush,
    input  logic [3:0]            exe_cmd,
    input  logic                  s_en,
    input  logic                  mem_read_en_in,
    input  logic                  mem_write_en_in,
    input  logic                  wb_en_in,
    input  logic                  b_in,
    input  logic [DATA_W-1:0]     pc,
    input  logic [DATA_W-1:0]     val_rn,
    input  logic [DATA_W-1:0]     val_rm_in,
    input  logic                  imm,
    input  logic [11:0]           shift_operand,
    input  logic [23:0]           signed_imm_24,
    input  logic [REG_ADDR_W-1:0] dest_in,
    input  logic [1:0]            sel_src1,
    input  logic [1:0]            sel_src2,
    input  logic [DATA_W-1:0]     alu_res_mem,
    input  logic [DATA_W-1:0]     wb_value,
    output logic                  stall_out,
    output logic                  valid_out,
    output logic                  mem_read_en,
    output logic                  mem_write_en,
    output logic                  wb_en,
    output logic                  br_taken,
    output logic [DATA_W-1:0]     alu_res,
    output logic [DATA_W-1:0]     val_rm,
    output logic [DATA_W-1:0]     br_addr,
    output logic [REG_ADDR_W-1:0] dest,
    output logic [3:0]            status_reg
);

    localparam int c_ITER  = DATA_W / BITS_PER_CYCLE;
    localparam int c_CNT_W = (c_ITER > 1) ? $clog2(c_ITER) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_ITER - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [DATA_W-1:0] w_op1, w_rm, w_val2, w_add_b, w_alu_res;
    logic [DATA_W-1:0] w_partial, w_br_addr;
    logic [DATA_W:0]   w_sum;
    logic              w_cin, w_arith, w_known, w_is_mul;
    logic              w_issue, w_accept_mul, w_mul_done;
    logic signed [25:0] w_br_off;
    nzcv_t             w_flags_alu, w_flags_mul;

    logic [1:0]            r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]     r_acc, r_mcand, r_mplier;
    logic                  r_h_s_en, r_h_mem_read, r_h_mem_write, r_h_wb_en, r_h_b;
    logic [DATA_W-1:0]     r_h_val_rm, r_h_br_addr;
    logic [REG_ADDR_W-1:0] r_h_dest;

    logic                  r_valid_out, r_mem_read, r_mem_write, r_wb_en, r_br_taken;
    logic [DATA_W-1:0]     r_alu_res, r_val_rm, r_br_addr;
    logic [REG_ADDR_W-1:0] r_dest;
    nzcv_t                 r_status;

    // Operand forwarding for Rn and Rm
    always_comb begin
        w_op1 = val_rn;
        w_rm  = val_rm_in;
        case (sel_src1)
            c_FWD_MEM: w_op1 = alu_res_mem;
            c_FWD_WB:  w_op1 = wb_value;
            default:   w_op1 = val_rn;
        endcase
        case (sel_src2)
            c_FWD_MEM: w_rm = alu_res_mem;
            c_FWD_WB:  w_rm = wb_value;
            default:   w_rm = val_rm_in;
        endcase
    end

    val2_gen_param #(
        .DATA_W (DATA_W)
    ) u_val2 (
        .i_rm            (w_rm),
        .i_shift_operand (shift_operand),
        .i_imm           (imm),
        .i_mem_en        (mem_read_en_in | mem_write_en_in),
        .o_val2          (w_val2)
    );

    // Shared adder: subtraction is op1 + ~val2 + carry-in, so C means "no borrow"
    always_comb begin
        w_add_b = w_val2;
        w_cin   = 1'b0;
        w_arith = 1'b0;
        case (exe_cmd)
            EXE_ADD: w_arith = 1'b1;
            EXE_ADC: begin w_arith = 1'b1; w_cin = r_status[c_FLAG_C]; end
            EXE_SUB: begin w_arith = 1'b1; w_add_b = ~w_val2; w_cin = 1'b1; end
            EXE_SBC: begin w_arith = 1'b1; w_add_b = ~w_val2; w_cin = r_status[c_FLAG_C]; end
            default: w_arith = 1'b0;
        endcase
        w_sum = {1'b0, w_op1} + {1'b0, w_add_b} + {{DATA_W{1'b0}}, w_cin};
    end

    // ALU result select; unknown opcodes give zero
    always_comb begin
        w_alu_res = '0;
        case (exe_cmd)
            EXE_MOV: w_alu_res = w_val2;
            EXE_MVN: w_alu_res = ~w_val2;
            EXE_AND: w_alu_res = w_op1 & w_val2;
            EXE_ORR: w_alu_res = w_op1 | w_val2;
            EXE_EOR: w_alu_res = w_op1 ^ w_val2;
            default: w_alu_res = w_arith ? w_sum[DATA_W-1:0] : '0;
        endcase
    end

    // Next flags: N/Z always from the result, C/V only from arithmetic
    always_comb begin
        w_flags_alu           = r_status;
        w_flags_alu[c_FLAG_N] = w_alu_res[DATA_W-1];
        w_flags_alu[c_FLAG_Z] = (w_alu_res == '0);
        if (w_arith) begin
            w_flags_alu[c_FLAG_C] = w_sum[DATA_W];
            w_flags_alu[c_FLAG_V] = (w_op1[DATA_W-1] == w_add_b[DATA_W-1]) &&
                                    (w_sum[DATA_W-1] != w_op1[DATA_W-1]);
        end
        w_flags_mul           = r_status;
        w_flags_mul[c_FLAG_N] = r_acc[DATA_W-1];
        w_flags_mul[c_FLAG_Z] = (r_acc == '0);
    end

    assign w_br_off  = $signed({signed_imm_24, 2'b00});
    assign w_br_addr = pc + DATA_W'(w_br_off);
    assign w_partial = r_mcand * {{(DATA_W-BITS_PER_CYCLE){1'b0}}, r_mplier[BITS_PER_CYCLE-1:0]};

    assign w_known      = exe_cmd_is_alu(exe_cmd);
    assign w_is_mul     = (exe_cmd == EXE_MUL);
    assign w_issue      = (r_state == c_ST_IDLE) && valid_in && !flush && !w_is_mul;
    assign w_accept_mul = (r_state == c_ST_IDLE) && valid_in && !flush && w_is_mul;
    assign w_mul_done   = (r_state == c_ST_DONE) && !flush;

    // Upstream hold while a multiply is being accepted or iterating
    always_comb begin
        case (r_state)
            c_ST_IDLE: stall_out = w_accept_mul;
            c_ST_BUSY: stall_out = !flush;
            default:   stall_out = 1'b0;
        endcase
    end

    // Multiply FSM: latch operands, retire one multiplier digit per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_cnt         <= '0;
            r_acc         <= '0;
            r_mcand       <= '0;
            r_mplier      <= '0;
            r_h_s_en      <= 1'b0;
            r_h_mem_read  <= 1'b0;
            r_h_mem_write <= 1'b0;
            r_h_wb_en     <= 1'b0;
            r_h_b         <= 1'b0;
            r_h_val_rm    <= '0;
            r_h_br_addr   <= '0;
            r_h_dest      <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept_mul) begin
                        r_state       <= c_ST_BUSY;
                        r_cnt         <= '0;
                        r_acc         <= '0;
                        r_mcand       <= w_op1;
                        r_mplier      <= w_val2;
                        r_h_s_en      <= s_en;
                        r_h_mem_read  <= mem_read_en_in;
                        r_h_mem_write <= mem_write_en_in;
                        r_h_wb_en     <= wb_en_in;
                        r_h_b         <= b_in;
                        r_h_val_rm    <= w_rm;
                        r_h_br_addr   <= w_br_addr;
                        r_h_dest      <= dest_in;
                    end
                end
                c_ST_BUSY: begin
                    if (flush) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_acc    <= r_acc + w_partial;
                        r_mcand  <= r_mcand << BITS_PER_CYCLE;
                        r_mplier <= r_mplier >> BITS_PER_CYCLE;
                        r_cnt    <= r_cnt + 1'b1;
                        if (r_cnt == c_CNT_LAST) begin
                            r_state <= c_ST_DONE;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // EXE/MEM register and status flags; bubble unless something completes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_out <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_wb_en     <= 1'b0;
            r_br_taken  <= 1'b0;
            r_alu_res   <= '0;
            r_val_rm    <= '0;
            r_br_addr   <= '0;
            r_dest      <= '0;
            r_status    <= '0;
        end else begin
            r_valid_out <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_wb_en     <= 1'b0;
            r_br_taken  <= 1'b0;
            r_alu_res   <= '0;
            r_val_rm    <= '0;
            r_br_addr   <= '0;
            r_dest      <= '0;
            if (w_issue) begin
                r_valid_out <= 1'b1;
                r_mem_read  <= mem_read_en_in;
                r_mem_write <= mem_write_en_in;
                r_wb_en     <= wb_en_in;
                r_br_taken  <= b_in;
                r_alu_res   <= w_alu_res;
                r_val_rm    <= w_rm;
                r_br_addr   <= w_br_addr;
                r_dest      <= dest_in;
                if (s_en && w_known) begin
                    r_status <= w_flags_alu;
                end
            end else if (w_mul_done) begin
                r_valid_out <= 1'b1;
                r_mem_read  <= r_h_mem_read;
                r_mem_write <= r_h_mem_write;
                r_wb_en     <= r_h_wb_en;
                r_br_taken  <= r_h_b;
                r_alu_res   <= r_acc;
                r_val_rm    <= r_h_val_rm;
                r_br_addr   <= r_h_br_addr;
                r_dest      <= r_h_dest;
                if (r_h_s_en) begin
                    r_status <= w_flags_mul;
                end
            end
        end
    end

    assign valid_out    = r_valid_out;
    assign mem_read_en  = r_mem_read;
    assign mem_write_en = r_mem_write;
    assign wb_en        = r_wb_en;
    assign br_taken     = r_br_taken;
    assign alu_res      = r_alu_res;
    assign val_rm       = r_val_rm;
    assign br_addr      = r_br_addr;
    assign dest         = r_dest;
    assign status_reg   = r_status;

endmodule
`default_nettype wire
